// File: rtl/ggt_pkg.sv
// Shared definitions for the binary GCD (ggT) core: FSM state encoding and
// the derived step-counter width.
package ggt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must hold the worst-case number of LOOP cycles, 4*w+2.
    function automatic int ggt_cnt_w(input int w);
        return $clog2(4 * w + 3);
    endfunction

endpackage

// File: rtl/ggt_step.sv
// One combinational step of Stein's binary GCD: reduces (a, b, k) once, or
// flags completion and presents the shifted result.
module ggt_step #(
    parameter int WIDTH = 16,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             fin,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        a_nxt = a;
        b_nxt = b;
        k_nxt = k;
        fin   = 1'b0;
        res   = '0;
        if (a == '0 || b == '0 || a == b) begin
            // a|b is the non-zero operand, or a itself when both are equal.
            fin = 1'b1;
            res = (a | b) << k;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + 1'b1;
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a >= b) begin
            a_nxt = a - b;
        end else begin
            b_nxt = b - a;
        end
    end

endmodule

// File: rtl/ggt_core.sv
// Parametrised binary GCD core: FSM, operand registers and step counter
// around the combinational ggt_step datapath. All outputs are registered.
module ggt_core
    import ggt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = ggt_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic [WIDTH-1:0] ergebnis,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] zyklen_o
);

    localparam int KW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, res;
    logic [KW-1:0]    k_q, k_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             fin;

    ggt_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a     (a_q),
        .b     (b_q),
        .k     (k_q),
        .a_nxt (a_nxt),
        .b_nxt (b_nxt),
        .k_nxt (k_nxt),
        .fin   (fin),
        .res   (res)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_LOOP;
            ST_LOOP: if (fin)     state_nxt = ST_DONE;
            ST_DONE:              state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            ergebnis <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            zyklen_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        a_q    <= Zahl1_i;
                        b_q    <= Zahl2_i;
                        k_q    <= '0;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ST_LOOP: begin
                    a_q   <= a_nxt;
                    b_q   <= b_nxt;
                    k_q   <= k_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_DONE: begin
                    // a/b/k are frozen on the finishing step, so res is still valid here.
                    ergebnis <= res;
                    zyklen_o <= cnt_q;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ggt_core.sv
// Directed and random checks of ggt_core at WIDTH 16 (directed), 8 and 32 (random).
module tb_ggt_core;

    localparam int CW16 = ggt_pkg::ggt_cnt_w(16);
    localparam int CW8  = ggt_pkg::ggt_cnt_w(8);
    localparam int CW32 = ggt_pkg::ggt_cnt_w(32);

    logic clk = 1'b0;
    logic rst;
    logic        start  [3];
    logic [31:0] z1     [3];
    logic [31:0] z2     [3];
    logic        done_v [3];
    logic        busy_v [3];

    logic [15:0]     erg16;
    logic [7:0]      erg8;
    logic [31:0]     erg32;
    logic [CW16-1:0] zy16;
    logic [CW8-1:0]  zy8;
    logic [CW32-1:0] zy32;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ggt_core #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start_i(start[0]),
        .Zahl1_i(z1[0][15:0]), .Zahl2_i(z2[0][15:0]),
        .ergebnis(erg16), .busy_o(busy_v[0]), .done_o(done_v[0]), .zyklen_o(zy16)
    );

    ggt_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start[1]),
        .Zahl1_i(z1[1][7:0]), .Zahl2_i(z2[1][7:0]),
        .ergebnis(erg8), .busy_o(busy_v[1]), .done_o(done_v[1]), .zyklen_o(zy8)
    );

    ggt_core #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start[2]),
        .Zahl1_i(z1[2]), .Zahl2_i(z2[2]),
        .ergebnis(erg32), .busy_o(busy_v[2]), .done_o(done_v[2]), .zyklen_o(zy32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] erg_of(input int u);
        case (u)
            0:       return {16'b0, erg16};
            1:       return {24'b0, erg8};
            default: return erg32;
        endcase
    endfunction

    function automatic int zy_of(input int u);
        case (u)
            0:       return int'(zy16);
            1:       return int'(zy8);
            default: return int'(zy32);
        endcase
    endfunction

    function automatic int width_of(input int u);
        case (u)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    // Euclid by remainder: deliberately a different algorithm from the DUT.
    function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic do_start(input int u, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start[u] = 1'b1;
        z1[u]    = x;
        z2[u]    = y;
        @(posedge clk);
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // Entered at the negedge following the accepting edge; lat counts edges to done_o.
    task automatic wait_done(input int u, output logic [31:0] r, output int zy, output int lat,
                             output bit busy_ok, output bit pulse_ok);
        bit seen = 1'b0;
        int c    = 0;
        busy_ok  = busy_v[u];
        pulse_ok = 1'b1;
        while (!seen && c < 200) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (done_v[u]) seen = 1'b1;
            else if (!busy_v[u]) busy_ok = 1'b0;
        end
        check($sformatf("done_seen_u%0d", u), 64'(seen), 64'd1);
        r   = erg_of(u);
        zy  = zy_of(u);
        lat = c;
        if (busy_v[u]) busy_ok = 1'b0;
        @(negedge clk);
        if (done_v[u]) pulse_ok = 1'b0;
    endtask

    task automatic run_chk(input string tag, input int u, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_r, input int exp_zy);
        logic [31:0] r;
        int zy, lat;
        bit busy_ok, pulse_ok;
        do_start(u, x, y);
        wait_done(u, r, zy, lat, busy_ok, pulse_ok);
        check({tag, "_result"}, 64'(r), 64'(exp_r));
        if (exp_zy >= 0) begin
            check({tag, "_zyklen"}, 64'(zy), 64'(exp_zy));
            check({tag, "_latency"}, 64'(lat), 64'(exp_zy + 1));
        end
        check({tag, "_bound"}, 64'(zy <= 4 * width_of(u) + 2), 64'd1);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_pulse"}, 64'(pulse_ok), 64'd1);
    endtask

    initial begin
        logic [31:0] r, x, y;
        int zy, lat, ndone;
        bit busy_ok, pulse_ok;

        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0;
            z1[u]    = '0;
            z2[u]    = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ergebnis", 64'(erg16), 64'd0);
        check("rst_busy",     64'(busy_v[0]), 64'd0);
        check("rst_done",     64'(done_v[0]), 64'd0);
        check("rst_zyklen",   64'(zy16), 64'd0);
        rst = 1'b0;

        run_chk("g356_238",   0, 356,   238,   2,     -1);
        run_chk("g48_18",     0, 48,    18,    6,     7);
        run_chk("g32768_1024",0, 32768, 1024,  1024,  16);
        run_chk("g17_0",      0, 17,    0,     17,    1);
        run_chk("g0_0",       0, 0,     0,     0,     1);
        run_chk("gffff_ffff", 0, 65535, 65535, 65535, 1);
        run_chk("g1_ffff",    0, 1,     65535, 1,     31);
        run_chk("gffff_1",    0, 65535, 1,     1,     31);
        run_chk("g32_1_max",  2, 1,     32'hffff_ffff, 1, 63);

        // A second start during LOOP must be dropped, not queued.
        do_start(0, 1, 65535);
        repeat (3) @(negedge clk);
        start[0] = 1'b1;
        z1[0]    = 48;
        z2[0]    = 18;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, r, zy, lat, busy_ok, pulse_ok);
        check("ign_result", 64'(r), 64'd1);
        check("ign_zyklen", 64'(zy), 64'd31);
        check("ign_pulse",  64'(pulse_ok), 64'd1);
        run_chk("after_ign", 0, 48, 18, 6, 7);

        // Reset mid-LOOP aborts with no done_o.
        do_start(0, 1, 65535);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ergebnis", 64'(erg16), 64'd0);
        check("abort_busy",     64'(busy_v[0]), 64'd0);
        check("abort_done",     64'(done_v[0]), 64'd0);
        check("abort_zyklen",   64'(zy16), 64'd0);
        rst   = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        run_chk("after_abort", 0, 356, 238, 2, -1);

        for (int u = 1; u < 3; u++) begin
            for (int i = 0; i < 20; i++) begin
                x = $urandom;
                y = $urandom;
                if (u == 1) begin
                    x &= 32'hff;
                    y &= 32'hff;
                end
                if (i == 3) x = 0;
                if (i == 5) y = 0;
                if (i == 7) y = x;
                do_start(u, x, y);
                wait_done(u, r, zy, lat, busy_ok, pulse_ok);
                check($sformatf("rnd_w%0d_%0d_res(%0d,%0d)", width_of(u), i, x, y), 64'(r), 64'(gcd_ref(x, y)));
                check($sformatf("rnd_w%0d_%0d_bound", width_of(u), i), 64'(zy >= 1 && zy <= 4 * width_of(u) + 2), 64'd1);
                check($sformatf("rnd_w%0d_%0d_latency", width_of(u), i), 64'(lat), 64'(zy + 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
